rs_adder_station: RTL and testbench

- Parametrised reservation station for the adder functional units in the Tomasulo core.
- Holds up to ENTRIES renamed add/sub instructions and snoops the common data bus (CDB) for missing operands.
- Each cycle it dispatches the oldest entry with both operands present to the FU over a valid/ready handshake.
- Register-status lookup is upstream. Issue delivers operands already renamed (tag or value); completion returns on the CDB.

---
 rtl/rs_adder_station.sv | 185 ++++++++++++++++++
 tb/tb_rs_adder_station.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_adder_station.sv
// Reservation station for the adder functional units of the Tomasulo core.
// Holds renamed add/sub instructions, snoops the CDB for missing operands and
// offers the oldest operand-complete line to the FU over a valid/ready handshake.
// Line i owns tag TAG_BASE+i; ages of busy lines are dense, 0 being the oldest.
module rs_adder_station #(
  parameter int ENTRIES  = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1,
  parameter int OP_W     = 3
) (
  input  logic                           Clock,
  input  logic                           Resetn,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [OP_W-1:0]                issue_op,
  input  logic [TAG_W-1:0]               issue_qj,
  input  logic [DATA_W-1:0]              issue_vj,
  input  logic [TAG_W-1:0]               issue_qk,
  input  logic [DATA_W-1:0]              issue_vk,
  output logic [TAG_W-1:0]               issue_tag,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_value,
  output logic                           disp_valid,
  input  logic                           disp_ready,
  output logic [OP_W-1:0]                disp_op,
  output logic [DATA_W-1:0]              disp_vj,
  output logic [DATA_W-1:0]              disp_vk,
  output logic [TAG_W-1:0]               disp_tag,
  input  logic                           flush,
  output logic [ENTRIES-1:0]             busy,
  output logic [$clog2(ENTRIES+1)-1:0]   count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);

  // Per-line state
  logic [ENTRIES-1:0] r_busy;
  logic [OP_W-1:0]    r_op  [ENTRIES];
  logic [TAG_W-1:0]   r_qj  [ENTRIES];
  logic [DATA_W-1:0]  r_vj  [ENTRIES];
  logic [TAG_W-1:0]   r_qk  [ENTRIES];
  logic [DATA_W-1:0]  r_vk  [ENTRIES];
  logic [IDX_W-1:0]   r_age [ENTRIES];

  logic [ENTRIES-1:0] w_ready;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_sel_age;
  logic [CNT_W-1:0]   w_count;
  logic               w_issue_fire;
  logic               w_disp_fire;
  logic               w_cdb_hit;
  logic [IDX_W-1:0]   w_new_age;

  // A line is dispatchable once both operands are present in registered state
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
    end
  end

  // Lowest-index free line receives the next issued instruction
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!r_busy[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end else begin
      end
    end
  end

  // Pick the oldest ready line (smallest age; ages are unique among busy lines)
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_ready[i] && (!w_sel_found || (r_age[i] < w_sel_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_age   = r_age[i];
      end else begin
      end
    end
  end

  // Occupancy count of busy lines
  always_comb begin
    w_count = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_count = w_count + CNT_W'(r_busy[i]);
    end
  end

  assign w_issue_fire = issue_valid && w_free_found;
  assign w_disp_fire  = w_sel_found && disp_ready;
  assign w_cdb_hit    = cdb_valid && (cdb_tag != '0);
  // A line issued on the same edge as a dispatch lands behind the survivors.
  assign w_new_age    = IDX_W'(w_count) - IDX_W'(w_disp_fire);

  assign issue_ready = w_free_found;
  assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
  assign disp_valid  = w_sel_found;
  assign disp_op     = w_sel_found ? r_op[w_sel_idx] : '0;
  assign disp_vj     = w_sel_found ? r_vj[w_sel_idx] : '0;
  assign disp_vk     = w_sel_found ? r_vk[w_sel_idx] : '0;
  assign disp_tag    = w_sel_found ? (TAG_W'(TAG_BASE) + TAG_W'(w_sel_idx)) : '0;
  assign busy        = r_busy;
  assign count       = w_count;

  // Line state: flush beats everything; otherwise dispatch, issue with CDB
  // bypass, and CDB snoop plus age compaction all apply in the same edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_busy <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_op[i]  <= '0;
        r_qj[i]  <= '0;
        r_vj[i]  <= '0;
        r_qk[i]  <= '0;
        r_vk[i]  <= '0;
        r_age[i] <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_disp_fire && (w_sel_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
          r_qj[i]   <= '0;
          r_qk[i]   <= '0;
        end else if (w_issue_fire && (w_free_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= issue_op;
          r_age[i]  <= w_new_age;
          if (w_cdb_hit && (issue_qj == cdb_tag)) begin
            r_qj[i] <= '0;
            r_vj[i] <= cdb_value;
          end else begin
            r_qj[i] <= issue_qj;
            r_vj[i] <= issue_vj;
          end
          if (w_cdb_hit && (issue_qk == cdb_tag)) begin
            r_qk[i] <= '0;
            r_vk[i] <= cdb_value;
          end else begin
            r_qk[i] <= issue_qk;
            r_vk[i] <= issue_vk;
          end
        end else if (r_busy[i]) begin
          if (w_cdb_hit && (r_qj[i] == cdb_tag)) begin
            r_qj[i] <= '0;
            r_vj[i] <= cdb_value;
          end else begin
          end
          if (w_cdb_hit && (r_qk[i] == cdb_tag)) begin
            r_qk[i] <= '0;
            r_vk[i] <= cdb_value;
          end else begin
          end
          if (w_disp_fire && (r_age[i] > w_sel_age)) begin
            r_age[i] <= r_age[i] - IDX_W'(1);
          end else begin
          end
        end else begin
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_adder_station.sv
// Self-checking bench for rs_adder_station: scenario tasks with inline checks,
// plus a dispatch scoreboard fed at issue time and drained on FU accepts.
module tb_rs_adder_station;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [3:0]  issue_qj;
  logic [15:0] issue_vj;
  logic [3:0]  issue_qk;
  logic [15:0] issue_vk;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_op;
  logic [15:0] disp_vj;
  logic [15:0] disp_vk;
  logic [3:0]  disp_tag;
  logic        flush;
  logic [3:0]  busy;
  logic [2:0]  count;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  rs_adder_station #(.ENTRIES(4), .DATA_W(16), .TAG_W(4), .TAG_BASE(1), .OP_W(3)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
    .flush(flush), .busy(busy), .count(count)
  );

  always #5 Clock = ~Clock;

  // Scoreboard: every FU accept must match the oldest outstanding expectation
  always @(negedge Clock) begin
    #4;
    if (Resetn && !flush && disp_valid && disp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_unexpected: got tag %0d op %0d, expected no dispatch", disp_tag, disp_op);
      end else begin
        mon_e = exp_q.pop_front();
        if (disp_op !== mon_e.op || disp_vj !== mon_e.vj || disp_vk !== mon_e.vk || disp_tag !== mon_e.tag) begin
          errors++;
          $display("FAIL disp_order: got op=%0d vj=%h vk=%h tag=%0d, expected op=%0d vj=%h vk=%h tag=%0d",
                   disp_op, disp_vj, disp_vk, disp_tag, mon_e.op, mon_e.vj, mon_e.vk, mon_e.tag);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge Clock);
    #2;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic [3:0] qj, input logic [15:0] vj,
                             input logic [3:0] qk, input logic [15:0] vk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_qj    = qj;
    issue_vj    = vj;
    issue_qk    = qk;
    issue_vk    = vk;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                          input logic [3:0] tag);
    exp_t e;
    e.op = op; e.vj = vj; e.vk = vk; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    cyc();
    cyc();
    checks++;
    if (issue_ready !== 1'b1 || disp_valid !== 1'b0 || count !== 3'd0 || issue_tag !== 4'd1) begin
      errors++;
      $display("FAIL reset_state: got ready=%b dv=%b count=%0d itag=%0d, expected 1 0 0 1",
               issue_ready, disp_valid, count, issue_tag);
    end
    checks++;
    if (busy !== 4'h0 || disp_tag !== 4'd0 || disp_vj !== 16'h0 || disp_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_disp: got busy=%h tag=%0d vj=%h op=%0d, expected all zero", busy, disp_tag, disp_vj, disp_op);
    end
    Resetn = 1'b1;
    cyc();
  endtask

  task automatic test_independent();
    drive_issue(3'd0, 4'd0, 16'd5, 4'd0, 16'd7);
    push_exp(3'd0, 16'd5, 16'd7, 4'd1);
    cyc();
    issue_valid = 1'b0;
    checks++;
    if (disp_valid !== 1'b1 || disp_vj !== 16'd5 || disp_vk !== 16'd7 || disp_tag !== 4'd1) begin
      errors++;
      $display("FAIL indep_offer: got dv=%b vj=%0d vk=%0d tag=%0d, expected 1 5 7 1", disp_valid, disp_vj, disp_vk, disp_tag);
    end
    disp_ready = 1'b1;
    cyc();
    disp_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL indep_drain: got count=%0d dv=%b, expected 0 0", count, disp_valid);
    end
  endtask

  task automatic test_cdb_bypass();
    drive_issue(3'd1, 4'd9, 16'h0000, 4'd0, 16'h0003);
    push_exp(3'd1, 16'h1234, 16'h0003, 4'd1);
    cyc();
    checks++;
    if (disp_valid !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL bypass_wait: got dv=%b count=%0d, expected 0 1", disp_valid, count);
    end
    drive_issue(3'd2, 4'd0, 16'h0004, 4'd9, 16'h0000);
    push_exp(3'd2, 16'h0004, 16'h1234, 4'd2);
    cdb_valid = 1'b1;
    cdb_tag   = 4'd9;
    cdb_value = 16'h1234;
    cyc();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    checks++;
    if (disp_valid !== 1'b1 || disp_tag !== 4'd1 || disp_vj !== 16'h1234) begin
      errors++;
      $display("FAIL bypass_wake: got dv=%b tag=%0d vj=%h, expected 1 1 1234", disp_valid, disp_tag, disp_vj);
    end
    disp_ready = 1'b1;
    cyc();
    checks++;
    if (disp_valid !== 1'b1 || disp_tag !== 4'd2 || disp_vk !== 16'h1234) begin
      errors++;
      $display("FAIL bypass_second: got dv=%b tag=%0d vk=%h, expected 1 2 1234", disp_valid, disp_tag, disp_vk);
    end
    cyc();
    disp_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL bypass_drain: got count=%0d, expected 0", count);
    end
  endtask

  task automatic test_age_order();
    for (int i = 0; i < 3; i++) begin
      drive_issue(3'(i), 4'd9, 16'h0010 + 16'(i), 4'd0, 16'h0020 + 16'(i));
      cyc();
    end
    drive_issue(3'd3, 4'd0, 16'h0013, 4'd0, 16'h0023);
    push_exp(3'd3, 16'h0013, 16'h0023, 4'd4);
    for (int i = 0; i < 3; i++) push_exp(3'(i), 16'hABCD, 16'h0020 + 16'(i), 4'(i + 1));
    cyc();
    issue_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || issue_ready !== 1'b0 || disp_tag !== 4'd4) begin
      errors++;
      $display("FAIL age_fill: got count=%0d ready=%b dtag=%0d, expected 4 0 4", count, issue_ready, disp_tag);
    end
    disp_ready = 1'b1;
    cyc();
    checks++;
    if (issue_tag !== 4'd4 || count !== 3'd3 || disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL age_first: got itag=%0d count=%0d dv=%b, expected 4 3 0", issue_tag, count, disp_valid);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 4'd9;
    cdb_value = 16'hABCD;
    cyc();
    cdb_valid = 1'b0;
    checks++;
    if (disp_valid !== 1'b1 || disp_tag !== 4'd1) begin
      errors++;
      $display("FAIL age_oldest: got dv=%b tag=%0d, expected 1 1", disp_valid, disp_tag);
    end
    cyc();
    cyc();
    cyc();
    disp_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL age_drain: got count=%0d, expected 0", count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_issue(3'(4 + i), 4'd0, 16'h0100 + 16'(i), 4'd0, 16'h0200 + 16'(i));
      push_exp(3'(4 + i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 4'(i + 1));
      cyc();
    end
    drive_issue(3'd1, 4'd0, 16'h0055, 4'd0, 16'h0066);
    checks++;
    if (count !== 3'd4 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d ready=%b, expected 4 0", count, issue_ready);
    end
    cyc();
    checks++;
    if (count !== 3'd4 || busy !== 4'hF) begin
      errors++;
      $display("FAIL full_hold: got count=%0d busy=%h, expected 4 f", count, busy);
    end
    disp_ready = 1'b1;
    cyc();
    disp_ready = 1'b0;
    checks++;
    if (issue_ready !== 1'b1 || count !== 3'd3 || issue_tag !== 4'd1) begin
      errors++;
      $display("FAIL full_release: got ready=%b count=%0d itag=%0d, expected 1 3 1", issue_ready, count, issue_tag);
    end
    push_exp(3'd1, 16'h0055, 16'h0066, 4'd1);
    cyc();
    issue_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || disp_tag !== 4'd2) begin
      errors++;
      $display("FAIL full_refill: got count=%0d dtag=%0d, expected 4 2", count, disp_tag);
    end
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    disp_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL full_drain: got count=%0d, expected 0", count);
    end
  endtask

  task automatic test_back_to_back();
    drive_issue(3'd2, 4'd0, 16'h0001, 4'd0, 16'h0002);
    push_exp(3'd2, 16'h0001, 16'h0002, 4'd1);
    cyc();
    drive_issue(3'd3, 4'd0, 16'h0003, 4'd0, 16'h0004);
    push_exp(3'd3, 16'h0003, 16'h0004, 4'd2);
    disp_ready = 1'b1;
    cyc();
    checks++;
    if (issue_tag !== 4'd1 || disp_tag !== 4'd2 || count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_swap: got itag=%0d dtag=%0d count=%0d, expected 1 2 1", issue_tag, disp_tag, count);
    end
    drive_issue(3'd4, 4'd0, 16'h0005, 4'd0, 16'h0006);
    push_exp(3'd4, 16'h0005, 16'h0006, 4'd1);
    cyc();
    issue_valid = 1'b0;
    checks++;
    if (disp_tag !== 4'd1 || count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_third: got dtag=%0d count=%0d, expected 1 1", disp_tag, count);
    end
    cyc();
    disp_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_drain: got count=%0d, expected 0", count);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(3'd5, 4'd9, 16'h0000, 4'd0, 16'h0001);
      cyc();
    end
    drive_issue(3'd6, 4'd0, 16'h0007, 4'd0, 16'h0008);
    flush = 1'b1;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: got count=%0d, expected 3", count);
    end
    cyc();
    flush       = 1'b0;
    issue_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || busy !== 4'h0 || disp_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got count=%0d busy=%h dv=%b ready=%b, expected 0 0 0 1", count, busy, disp_valid, issue_ready);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 4'd9;
    cdb_value = 16'h7777;
    cyc();
    cdb_valid = 1'b0;
    cyc();
    checks++;
    if (disp_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL flush_stale_cdb: got dv=%b count=%0d, expected 0 0", disp_valid, count);
    end
    drive_issue(3'd5, 4'd9, 16'h0000, 4'd0, 16'h0001);
    cyc();
    cyc();
    drive_issue(3'd6, 4'd0, 16'h0009, 4'd0, 16'h000A);
    cyc();
    issue_valid = 1'b0;
    checks++;
    if (count !== 3'd3 || disp_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got count=%0d dv=%b, expected 3 1", count, disp_valid);
    end
    #1;
    Resetn = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || busy !== 4'h0 || disp_valid !== 1'b0 || issue_tag !== 4'd1 || disp_tag !== 4'd0) begin
      errors++;
      $display("FAIL areset_async: got count=%0d busy=%h dv=%b itag=%0d dtag=%0d, expected 0 0 0 1 0",
               count, busy, disp_valid, issue_tag, disp_tag);
    end
    cyc();
    Resetn = 1'b1;
    cyc();
    drive_issue(3'd7, 4'd0, 16'h00AA, 4'd0, 16'h00BB);
    push_exp(3'd7, 16'h00AA, 16'h00BB, 4'd1);
    disp_ready = 1'b1;
    cyc();
    issue_valid = 1'b0;
    cyc();
    disp_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL areset_after: got count=%0d, expected 0", count);
    end
  endtask

  initial begin
    Resetn      = 1'b0;
    issue_valid = 1'b0;
    issue_op    = 3'd0;
    issue_qj    = 4'd0;
    issue_vj    = 16'd0;
    issue_qk    = 4'd0;
    issue_vk    = 16'd0;
    cdb_valid   = 1'b0;
    cdb_tag     = 4'd0;
    cdb_value   = 16'd0;
    disp_ready  = 1'b0;
    flush       = 1'b0;
    test_reset();
    test_independent();
    test_cdb_bypass();
    test_age_order();
    test_full();
    test_back_to_back();
    test_flush_reset();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d pending dispatches, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
